// File: rtl/karat_acc.sv
// rtl/karat_acc.sv - accumulates len 32-bit multiplier products into one wide result beat
// Optional build macro KARAT_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module karat_acc #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] add_res;

  // One extra bit above the accumulator exposes the carry out of bit ACC_W-1.
  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, prod_in};
    carry = sum[ACC_W];
`ifdef KARAT_ACC_SAT_EN
    // Once clamped, the sticky flag keeps the accumulator pinned at all-ones.
    add_res = (carry || ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    add_res = sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (len == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = len;
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_next = add_res;
          ovf_next = ovf | carry;
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (acc_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      prod_ready <= 1'b0;
      acc_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      cnt        <= cnt_next;
      ovf        <= ovf_next;
      prod_ready <= (state_next == ACCUM);
      acc_valid  <= (state_next == DONE);
      busy       <= (state_next != IDLE);
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_karat_acc.sv
// tb/tb_karat_acc.sv - bench for karat_acc: job-level sum model plus directed literal vectors
module tb_karat_acc;

  localparam int ACC_W = 36;
  localparam int CNT_W = 8;
`ifdef KARAT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [31:0]      prod_in;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             busy;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  karat_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .busy       (busy),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: a job's result is the plain sum of its accepted products.
  localparam longint unsigned LIMIT = 64'd1 << ACC_W;
  int              m_phase = 0;   // 0 idle, 1 taking products, 2 result offered
  int              m_rem = 0;
  longint unsigned m_total = 0;
  bit              m_after_rst = 0;
  bit              model_on = 0;

  function automatic logic [63:0] exp_out(input longint unsigned total);
    if (total < LIMIT) return total;
    return SAT ? (LIMIT - 1) : (total % LIMIT);
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_busy", busy, m_phase != 0);
      chk("m_prod_ready", prod_ready, m_phase == 1);
      chk("m_acc_valid", acc_valid, m_phase == 2);
      if (m_phase == 2 || m_after_rst) begin
        chk("m_acc_out", acc_out, m_after_rst ? 64'd0 : exp_out(m_total));
        chk("m_ovf", ovf, (!m_after_rst) && (m_total >= LIMIT));
      end
    end
    if (rst) begin
      m_phase     = 0;
      m_total     = 0;
      m_after_rst = 1;
      model_on    = 1;
    end else if (model_on) begin
      m_after_rst = 0;
      case (m_phase)
        0: if (start) begin
          m_total = 0;
          m_rem   = int'(len);
          m_phase = (len == 0) ? 2 : 1;
        end
        1: if (prod_valid) begin
          m_total += longint'(prod_in);
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
        default: if (acc_ready) m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    prod_valid = v;
    prod_in    = d;
    tick();
  endtask

  task automatic start_job(input logic [CNT_W-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!acc_valid && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_valid"}, acc_valid, 1'b1);
  endtask

  task automatic get_result(input string nm, input logic [63:0] e_out, input logic e_ovf);
    wait_valid(nm);
    chk({nm, "_out"}, acc_out, e_out);
    chk({nm, "_ovf"}, ovf, e_ovf);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_ovf", ovf, 0);

    // Basic three-beat job; result must appear the cycle after the last beat.
    start_job(8'd3);
    chk("basic_ready", prod_ready, 1);
    beat(1'b1, 32'h0000_0006);
    beat(1'b1, 32'h0000_000A);
    beat(1'b1, 32'hFFFF_FFFF);
    prod_valid = 1'b0;
    chk("basic_latency", acc_valid, 1);
    get_result("basic", 64'h1_0000_000F, 1'b0);

    // Zero-length job, then held result with start pulsed and products offered.
    tick();
    start_job(8'd0);
    chk("zero_latency", acc_valid, 1);
    for (int i = 0; i < 5; i++) begin
      start      = (i == 2);
      len        = 8'd5;
      prod_valid = 1'b1;
      prod_in    = 32'h9;
      chk("hold_prod_ready", prod_ready, 0);
      chk("hold_acc_out", acc_out, 0);
      tick();
    end
    start = 1'b0;
    prod_valid = 1'b0;
    get_result("zero", 64'h0, 1'b0);

    // Producer stalls: only valid beats count.
    start_job(8'd2);
    beat(1'b1, 32'h11);
    beat(1'b0, 32'hDEAD);
    beat(1'b0, 32'hBEEF);
    beat(1'b1, 32'h33);
    prod_valid = 1'b0;
    get_result("stall", 64'h44, 1'b0);

    // Overflow with 17 all-ones products.
    start_job(8'd17);
    for (int i = 0; i < 17; i++) beat(1'b1, 32'hFFFF_FFFF);
    prod_valid = 1'b0;
    get_result("overflow", SAT ? 64'hF_FFFF_FFFF : 64'h0_FFFF_FFEF, 1'b1);

    // The next job starts with ovf cleared.
    start_job(8'd1);
    beat(1'b1, 32'h2);
    prod_valid = 1'b0;
    get_result("ovf_clear", 64'h2, 1'b0);

    // Reset in the middle of a job.
    start_job(8'd4);
    beat(1'b1, 32'h100);
    beat(1'b1, 32'h200);
    prod_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_prod_ready", prod_ready, 0);
    chk("midrst_acc_valid", acc_valid, 0);
    chk("midrst_acc_out", acc_out, 0);
    chk("midrst_ovf", ovf, 0);
    start_job(8'd1);
    beat(1'b1, 32'h5);
    prod_valid = 1'b0;
    get_result("post_rst", 64'h5, 1'b0);

    // Products offered while idle are not consumed.
    prod_valid = 1'b1;
    prod_in    = 32'h1234;
    tick();
    chk("idle_prod_ready", prod_ready, 0);
    tick();
    chk("idle_prod_ready2", prod_ready, 0);
    start_job(8'd1);
    beat(1'b1, 32'h7);
    prod_valid = 1'b0;
    get_result("idle_prod", 64'h7, 1'b0);

    // Start held through the handshake is only taken after one idle cycle.
    start_job(8'd1);
    beat(1'b1, 32'h3);
    prod_valid = 1'b0;
    wait_valid("b2b_first");
    chk("b2b_first_out", acc_out, 64'h3);
    acc_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd1;
    tick();
    acc_ready = 1'b0;
    chk("b2b_gap_busy", busy, 0);
    tick();
    start = 1'b0;
    chk("b2b_second_ready", prod_ready, 1);
    beat(1'b1, 32'h8);
    prod_valid = 1'b0;
    get_result("b2b_second", 64'h8, 1'b0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/karat_acc.md
# karat_acc

Downstream accumulation stage for the 16x16 Karatsuba multiplier. It consumes the multiplier's 32-bit products through a valid/ready handshake and sums a programmed number of them (`len`) into a wide accumulator. It then presents the sum as one result beat. Together with the multiplier it forms a dot-product / multiply-accumulate datapath.

## Interface
Parameters:
- `ACC_W`, 40: accumulator and result width in bits. Must be ≥ 33.
- `CNT_W`, 8: width of the job-length field. Maximum products per job is 2^CNT_W − 1.

Ports:
- `clk`  in  1  clock. The block uses this single clock only.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job start request. Sampled only in IDLE.
- `len`  in  CNT_W  number of products in the job. Captured with `start`.
- `prod_in`  in  32  product from the multiplier (`C` output).
- `prod_valid`  in  1  `prod_in` is valid.
- `prod_ready`  out  1  the block accepts a product this cycle.
- `acc_out`  out  ACC_W  accumulated result.
- `acc_valid`  out  1  `acc_out` is valid.
- `acc_ready`  in  1  consumer accepts the result.
- `busy`  out  1  the block is not in IDLE.
- `ovf`  out  1  sticky overflow flag for the current job. Valid together with `acc_valid`.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `prod_ready`=0, `acc_valid`=0, `busy`=0.
  - `start`=1 with `len`≠0: clear the accumulator and `ovf`, load the down-counter with `len`, go to ACCUM.
  - `start`=1 with `len`=0: clear the accumulator and `ovf`, go to DONE. The result is 0.
  - While in IDLE, `prod_valid` is ignored and no product is consumed.
- **ACCUM**
  - `prod_ready`=1.
  - Each cycle with `prod_valid`=1: add `prod_in`, zero-extended to ACC_W+1 bits, to the accumulator, and decrement the counter.
  - When the beat with counter==1 is accepted, go to DONE.
  - `start` is ignored in ACCUM.
- **DONE**
  - `acc_valid`=1 and `prod_ready`=0.
  - `acc_out` and `ovf` hold stable until `acc_ready`=1.
  - On the handshake cycle, go to IDLE.
  - `start` is ignored in DONE, including in the handshake cycle.
- **Arithmetic**
  - Unsigned arithmetic throughout.
  - If the carry out of bit ACC_W−1 is set on any add, `ovf` sets and stays set until the next job start.
  - Overflow handling is selected by the Configuration macro.
- **Reset:** on `rst`=1 at a clock edge, in any state including mid-job:
  - state goes to IDLE;
  - the accumulator and `acc_out` go to 0;
  - `ovf`, `acc_valid`, `prod_ready` and `busy` go to 0.
  - Any partially accumulated job is discarded.

## Timing
- All outputs are registered.
- Throughput is one product per cycle while in ACCUM.
- `acc_valid` rises on the cycle after the final product beat is accepted.
- `acc_valid` rises one cycle after `start` is accepted with `len`=0.
- Minimum gap between jobs: after the result handshake, the block spends one cycle in IDLE before the next `start` can be accepted.
- Consumer backpressure: `acc_ready` may stay low indefinitely. No product is accepted during that time.
- Producer stalls: `prod_valid`=0 during ACCUM leaves the accumulator and counter unchanged.

## Configuration
- Macro `KARAT_ACC_SAT_EN`.
- **Defined:** on overflow the accumulator clamps to all-ones (2^ACC_W − 1) and stays there for the rest of the job. Further adds do not change it.
- **Undefined:** the accumulator wraps modulo 2^ACC_W.
- In both builds, `ovf` behaves identically.

## Test plan
- **Basic job:** `len`=3, products 0x0000_0006, 0x0000_000A, 0xFFFF_FFFF, one per cycle → `acc_out`=0x01_0000_000F, `ovf`=0, `acc_valid` high on the cycle after the third beat.
- **Zero-length job:** `start` with `len`=0 → next cycle `acc_valid`=1, `acc_out`=0. `prod_ready` never asserts.
- **Overflow, ACC_W=36:** 17 products of 0xFFFF_FFFF.
  - Without the macro: `acc_out`=0x0_FFFF_FFEF, `ovf`=1.
  - With `KARAT_ACC_SAT_EN`: `acc_out`=0xF_FFFF_FFFF, `ovf`=1.
- **Backpressure and stalls:**
  - `prod_valid` toggles 1,0,0,1 with `len`=2 → only the two valid beats are summed.
  - Hold `acc_ready`=0 for 5 cycles → `acc_out` stable, `prod_ready`=0 throughout.
  - `start` pulsed during DONE is ignored.
- **Reset mid-job:** `len`=4, assert `rst` after 2 beats → next cycle all outputs are 0 and the FSM is in IDLE. A new job with `len`=1 and product 0x5 then yields `acc_out`=0x5.
- **Idle products:** `prod_valid`=1 with 0x1234 while in IDLE → `prod_ready`=0, and a following `len`=1 job with 0x7 gives `acc_out`=0x7.
